// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter (mem_port_arbiter).
package mem_arb_pkg;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// Saturating up-counter with enable and synchronous clear; holds at MAX.
module mem_arb_sat_cnt #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter between CPU and loader with loader burst limit.
// Optional saturating CPU stall counter enabled by MEM_ARB_STALL_CNT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW            = AW_DEF,
    parameter int DW            = DW_DEF,
    parameter int MAX_LDR_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
`ifdef MEM_ARB_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] cpu_stall_cnt
`endif
);

    localparam int BW = $clog2(MAX_LDR_BURST + 1);

    owner_e        owner_q, owner_d;
    owner_e        rd_owner;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic          mem_we_q, mem_we_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          ldr_rvalid_q, ldr_rvalid_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic [BW-1:0] burst_cnt;
    logic          cpu_win, ldr_win;

    // Loader keeps priority until it has won MAX_LDR_BURST times over a waiting CPU.
    always_comb begin
        cpu_win = 1'b0;
        ldr_win = 1'b0;
        owner_d = OWN_IDLE;
        if (ldr_req && (!cpu_req || (burst_cnt < BW'(MAX_LDR_BURST)))) begin
            ldr_win = 1'b1;
            owner_d = OWN_LDR;
        end else if (cpu_req) begin
            cpu_win = 1'b1;
            owner_d = OWN_CPU;
        end
    end

    assign cpu_gnt   = cpu_win;
    assign ldr_gnt   = ldr_win;
    assign cpu_stall = cpu_req & ~cpu_win;

    mem_arb_sat_cnt #(
        .W   (BW),
        .MAX (BW'(MAX_LDR_BURST))
    ) u_burst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ldr_win & cpu_req),
        .clr   (cpu_win | ~cpu_req),
        .cnt   (burst_cnt)
    );

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        mem_we_d   = 1'b0;
        if (ldr_win) begin
            mem_addr_d = ldr_addr;
            mem_wd_d   = ldr_wdata;
            mem_we_d   = ldr_we;
        end else if (cpu_win) begin
            mem_addr_d = cpu_addr;
            mem_wd_d   = cpu_wdata;
            mem_we_d   = cpu_we;
        end
    end

    // The command now on mem_* is a read only if its owner issued it with we=0.
    assign rd_owner = mem_we_q ? OWN_IDLE : owner_q;

    always_comb begin
        cpu_rvalid_d = (rd_owner == OWN_CPU);
        ldr_rvalid_d = (rd_owner == OWN_LDR);
        cpu_rdata_d  = cpu_rvalid_d ? mem_rd : cpu_rdata_q;
        ldr_rdata_d  = ldr_rvalid_d ? mem_rd : ldr_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_IDLE;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            mem_we_q     <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rvalid_q <= 1'b0;
            ldr_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            mem_we_q     <= mem_we_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rvalid_q <= ldr_rvalid_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;
    assign mem_we     = mem_we_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ldr_rvalid = ldr_rvalid_q;
    assign ldr_rdata  = ldr_rdata_q;

`ifdef MEM_ARB_STALL_CNT_EN
    mem_arb_sat_cnt #(
        .W   (STALL_CNT_W),
        .MAX ({STALL_CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cpu_stall),
        .clr   (1'b0),
        .cnt   (cpu_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid, mem_we;
    logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wd, mem_rd;
`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0] cpu_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [0:63];

    always #5 clk = ~clk;

    // Memory macro model; preloads fixed words while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_arr[0]  <= 32'hA0A0_A0A0;
            mem_arr[1]  <= 32'hB1B1_B1B1;
            mem_arr[4]  <= 32'hDEAD_BEEF;
            mem_arr[12] <= 32'h5555_0030;
        end else if (mem_we) begin
            mem_arr[mem_addr[7:2]] <= mem_wd;
        end
    end
    assign mem_rd = mem_arr[mem_addr[7:2]];

    mem_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
`ifdef MEM_ARB_STALL_CNT_EN
        ,
        .cpu_stall_cnt (cpu_stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL reset_cpu_gnt got %b exp 1", cpu_gnt);
        end
        ldr_req = 1'b1;
        #1;
        checks++;
        if ({ldr_gnt, cpu_gnt, cpu_stall} !== 3'b101) begin
            errors++; $display("FAIL reset_gnt_both got %b exp 101", {ldr_gnt, cpu_gnt, cpu_stall});
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick(); tick();
        checks++;
        if ({mem_addr, mem_wd, mem_we, cpu_rvalid, ldr_rvalid, cpu_rdata, ldr_rdata} !== '0) begin
            errors++; $display("FAIL reset_values addr %h wd %h we %b rv %b/%b rd %h/%h exp all 0",
                               mem_addr, mem_wd, mem_we, cpu_rvalid, ldr_rvalid, cpu_rdata, ldr_rdata);
        end
        $display("reset: outputs checked");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        #1;
        checks++;
        if ({cpu_gnt, cpu_stall} !== 2'b10) begin
            errors++; $display("FAIL cpu_read_gnt got %b exp 10", {cpu_gnt, cpu_stall});
        end
        tick();
        cpu_req = 1'b0;
        checks++;
        if (mem_addr !== 32'h10 || mem_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
            errors++; $display("FAIL cpu_read_cmd addr %h we %b rv %b exp 10 0 0", mem_addr, mem_we, cpu_rvalid);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF || ldr_rvalid !== 1'b0) begin
            errors++; $display("FAIL cpu_read_data rv %b data %h lrv %b exp 1 deadbeef 0", cpu_rvalid, cpu_rdata, ldr_rvalid);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++; $display("FAIL cpu_read_pulse rv %b exp 0", cpu_rvalid);
        end
        $display("cpu_read: addr 10 data %h", cpu_rdata);
    endtask

    task automatic test_ldr_write();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h20; ldr_wdata = 32'h1234;
        #1;
        checks++;
        if ({ldr_gnt, cpu_gnt} !== 2'b10) begin
            errors++; $display("FAIL ldr_write_gnt got %b exp 10", {ldr_gnt, cpu_gnt});
        end
        tick();
        ldr_req = 1'b0; ldr_we = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wd !== 32'h1234) begin
            errors++; $display("FAIL ldr_write_cmd we %b addr %h wd %h exp 1 20 1234", mem_we, mem_addr, mem_wd);
        end
        tick();
        checks++;
        if (mem_we !== 1'b0 || ldr_rvalid !== 1'b0 || mem_addr !== 32'h20) begin
            errors++; $display("FAIL ldr_write_after we %b lrv %b addr %h exp 0 0 20", mem_we, ldr_rvalid, mem_addr);
        end
        tick();
        checks++;
        if (ldr_rvalid !== 1'b0) begin
            errors++; $display("FAIL ldr_write_no_rvalid lrv %b exp 0", ldr_rvalid);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        tick();
        cpu_req = 1'b0;
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234) begin
            errors++; $display("FAIL ldr_write_readback rv %b data %h exp 1 1234", cpu_rvalid, cpu_rdata);
        end
        $display("ldr_write: addr 20 readback %h", cpu_rdata);
        tick();
    endtask

    task automatic test_burst();
        logic [9:0] exp_l;
        int cpu_rv_n;
        int ldr_rv_n;
        exp_l = 10'b1111011110;
        cpu_rv_n = 0;
        ldr_rv_n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h30;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) begin
                cpu_req = 1'b0; ldr_req = 1'b0;
            end
            #1;
            if (i < 10) begin
                checks++;
                if (ldr_gnt !== exp_l[9-i] || cpu_gnt !== ~exp_l[9-i] || cpu_stall !== exp_l[9-i]) begin
                    errors++; $display("FAIL burst_gnt cycle %0d got l%b c%b s%b exp l%b", i, ldr_gnt, cpu_gnt, cpu_stall, exp_l[9-i]);
                end
                $display("burst: cycle %0d grant %s", i, ldr_gnt ? "L" : "C");
            end
            if (cpu_rvalid === 1'b1) cpu_rv_n++;
            if (ldr_rvalid === 1'b1) ldr_rv_n++;
            tick();
        end
        checks++;
        if (cpu_rv_n != 2 || ldr_rv_n != 8) begin
            errors++; $display("FAIL burst_rvalid_cnt cpu %0d ldr %0d exp 2 8", cpu_rv_n, ldr_rv_n);
        end
        checks++;
        if (cpu_rdata !== 32'hDEAD_BEEF || ldr_rdata !== 32'h5555_0030) begin
            errors++; $display("FAIL burst_rdata cpu %h ldr %h exp deadbeef 55550030", cpu_rdata, ldr_rdata);
        end
        tick();
    endtask

    task automatic test_interleave();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL interleave_cpu_gnt got %b exp 1", cpu_gnt);
        end
        tick();
        cpu_req = 1'b0;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h4;
        #1;
        checks++;
        if (ldr_gnt !== 1'b1) begin
            errors++; $display("FAIL interleave_ldr_gnt got %b exp 1", ldr_gnt);
        end
        tick();
        ldr_req = 1'b0;
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA0A0_A0A0 || ldr_rvalid !== 1'b0 || ldr_rdata !== 32'h5555_0030) begin
            errors++; $display("FAIL interleave_n2 crv %b cd %h lrv %b ld %h exp 1 a0a0a0a0 0 55550030",
                               cpu_rvalid, cpu_rdata, ldr_rvalid, ldr_rdata);
        end
        tick();
        checks++;
        if (ldr_rvalid !== 1'b1 || ldr_rdata !== 32'hB1B1_B1B1 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hA0A0_A0A0) begin
            errors++; $display("FAIL interleave_n3 lrv %b ld %h crv %b cd %h exp 1 b1b1b1b1 0 a0a0a0a0",
                               ldr_rvalid, ldr_rdata, cpu_rvalid, cpu_rdata);
        end
        $display("interleave: cpu %h ldr %h", cpu_rdata, ldr_rdata);
        tick();
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        tick();
        cpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_addr !== 32'h0 || mem_we !== 1'b0 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || ldr_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mid_values addr %h we %b rv %b cd %h ld %h exp 0",
                               mem_addr, mem_we, cpu_rvalid, cpu_rdata, ldr_rdata);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_no_rvalid rv %b exp 0", cpu_rvalid);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cpu_rvalid !== 1'b0 || ldr_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_after rv %b/%b exp 0/0", cpu_rvalid, ldr_rvalid);
        end
        cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        checks++;
        if (mem_addr !== 32'h10) begin
            errors++; $display("FAIL reset_mid_cmd addr %h exp 10", mem_addr);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL reset_mid_recover rv %b data %h exp 1 deadbeef", cpu_rvalid, cpu_rdata);
        end
        $display("reset_mid: recovered read %h", cpu_rdata);
        tick();
    endtask

`ifdef MEM_ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst_n = 1'b0;
        #1;
        checks++;
        if (cpu_stall_cnt !== 16'h0) begin
            errors++; $display("FAIL stall_cnt_reset got %h exp 0", cpu_stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_addr = 32'h10; ldr_req = 1'b1; ldr_addr = 32'h30;
        tick(); tick(); tick();
        checks++;
        if (cpu_stall_cnt !== 16'd3) begin
            errors++; $display("FAIL stall_cnt_3 got %0d exp 3", cpu_stall_cnt);
        end
        $display("stall_cnt: after 3 stalls %0d", cpu_stall_cnt);
        for (int i = 0; i < 82000; i++) tick();
        checks++;
        if (cpu_stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL stall_cnt_sat got %h exp ffff", cpu_stall_cnt);
        end
        $display("stall_cnt: saturated %h", cpu_stall_cnt);
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_burst();
        test_interleave();
        test_reset_mid();
`ifdef MEM_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared instruction/data memory port between the multi-cycle CPU and a program loader/DMA requester. Accepts one single-word read or write per cycle from the winning requester, drives registered commands to the memory, and returns read data to the correct requester. The loader has priority, bounded by a burst limit that guarantees CPU forward progress. The block sits between the CPU/loader masters and the memory macro.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width.
- `MAX_LDR_BURST`, 4, maximum consecutive loader grants while the CPU is waiting; must be ≥1.

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_req`  in  1  CPU request; held with its payload until `cpu_gnt`.
- `cpu_we`  in  1  CPU write (1) or read (0).
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  combinational accept, same cycle as `cpu_req`.
- `cpu_rvalid`  out  1  one-cycle pulse with `cpu_rdata`.
- `cpu_rdata`  out  DW  CPU read data.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`: loader equivalents of the CPU ports, with identical widths and meanings.
- `mem_addr`  out  AW  registered memory address.
- `mem_wd`  out  DW  registered memory write data.
- `mem_we`  out  1  registered memory write enable.
- `mem_rd`  in  DW  memory read data, combinational from `mem_addr`.
- `cpu_stall_cnt`  out  16  saturating stall count; present only with `MEM_ARB_STALL_CNT_EN`.

## Operation
- Owner FSM (`OWN_IDLE`, `OWN_CPU`, `OWN_LDR`) records which requester owns the command currently on the `mem_*` ports. The next state is the winner of the current cycle, or `OWN_IDLE` if there is no request.
- Arbitration (combinational, every cycle):
  - Only one requester active: that requester wins.
  - Both active: the loader wins while `burst_cnt < MAX_LDR_BURST`; otherwise the CPU wins.
- `burst_cnt` behaviour:
  - Increments on each loader grant made while `cpu_req` is high.
  - Clears on any CPU grant or any cycle in which `cpu_req` is low.
  - Saturates at `MAX_LDR_BURST`.
- Grant effects: the winner's `gnt` is high in the accepting cycle and the loser's `gnt` is low. At the next edge, `addr`/`wdata`/`we` are registered onto `mem_*`.
- With no grant, `mem_we` registers 0. `mem_addr` and `mem_wd` hold their previous values.
- Read return: a registered `rd_owner` tag captures `mem_rd` at the end of the command cycle. The data appears on the owner's `rdata`, and its `rvalid` pulses for one cycle. The other requester's `rdata` is unchanged.
- Writes produce no response.
- Reset values: `mem_addr`=0, `mem_wd`=0, `mem_we`=0, both `rvalid`=0, both `rdata`=0, FSM=`OWN_IDLE`, `burst_cnt`=0, `cpu_stall_cnt`=0.
- The `gnt` and `cpu_stall` outputs are combinational and follow the request inputs during and after reset.

## Timing
- Cycle N: `req` and `gnt` are high (accept).
- Cycle N+1: the command is on `mem_*`, and the memory write commits at the end of N+1.
- Cycle N+2: `rdata`/`rvalid` are valid for reads. Read latency from accept is 2 cycles.
- Throughput is one accepted request per cycle. Back-to-back grants of either requester, or alternating requesters, are legal. In-flight reads return in order of acceptance.
- Reset asserted mid-operation: in-flight reads are discarded with no `rvalid`, `mem_we` drops immediately (asynchronous), and `burst_cnt` is lost.
- A requester may change its payload only after `gnt`. Dropping `req` before `gnt` is legal and has no side effects.

## Configuration
- With `MEM_ARB_STALL_CNT_EN` defined:
  - `cpu_stall_cnt` increments every cycle `cpu_stall` is high.
  - It saturates at 16'hFFFF and clears only on reset.
- Without it, the port and the counter logic are absent; arbitration is identical.

## Structure
- Package `mem_arb_pkg` holds:
  - the `owner_e` enum (`OWN_IDLE`, `OWN_CPU`, `OWN_LDR`);
  - the default `AW`/`DW`;
  - the stall-counter width constant (16).
- Sub-module `mem_arb_sat_cnt` is a parameterised saturating up-counter with enable. It is instantiated for `burst_cnt` and, under the macro, for `cpu_stall_cnt`.

## Test plan
- CPU read alone, `cpu_addr`=0x10, memory holds 0xDEADBEEF → `cpu_gnt` in cycle N, `mem_addr`=0x10 in N+1, `cpu_rdata`=0xDEADBEEF with `cpu_rvalid` in N+2.
- Loader write, `ldr_addr`=0x20, `ldr_wdata`=0x1234 → `mem_we`=1 for exactly one cycle, no `ldr_rvalid`; a subsequent CPU read of 0x20 returns 0x1234.
- Both requesters held continuously, `MAX_LDR_BURST`=4 → grant sequence L,L,L,L,C,L,L,L,L,C; `cpu_stall` is high on every loader-granted cycle.
- Interleaved reads with CPU@0x0 accepted in N and loader@0x4 accepted in N+1 → `cpu_rvalid` in N+2 and `ldr_rvalid` in N+3, each with its own data, no cross-delivery.
- `rst_n` pulsed low in the cycle after a read is accepted → no `rvalid`, and all outputs at their reset values; the next request after reset completes normally.
- With `MEM_ARB_STALL_CNT_EN` and the CPU blocked for 3 cycles → `cpu_stall_cnt`=3; after forcing 70000 stall cycles it holds at 0xFFFF.
